// File: rtl/spi_frame_writer_if.sv
// Frame-writer bus: serial video input side and double-buffered frame-memory write side.
// The master is the writer itself; the slave is whoever feeds MISO and owns the frame buffer.
interface spi_frame_writer_if #(
    parameter int WORD_W = 8,
    parameter int ADDR_W = 14
);
    logic              SPI_clk_en;
    logic              MISO;
    logic              video_data_ready;
    logic              frame_consumed;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic              wr_bank;
    logic              display_bank;
    logic              frame_done;
    logic              overflow;

    modport master (
        input  SPI_clk_en,
        input  MISO,
        input  video_data_ready,
        input  frame_consumed,
        output wr_en,
        output wr_addr,
        output wr_data,
        output wr_bank,
        output display_bank,
        output frame_done,
        output overflow
    );

    modport slave (
        output SPI_clk_en,
        output MISO,
        output video_data_ready,
        output frame_consumed,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  wr_bank,
        input  display_bank,
        input  frame_done,
        input  overflow
    );
endinterface

// File: rtl/spi_frame_writer.sv
// Deserialises MISO into words and writes them into one half of a double-buffered
// frame memory, swapping banks once the display side has released the other half.
module spi_frame_writer #(
    parameter int WORD_W     = 8,
    parameter int CELL_COUNT = 9600,
    parameter int ADDR_W     = 14
) (
    input  logic               CLK_40,
    input  logic               reset,
    spi_frame_writer_if.master bus
);
    localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WORD_W - 1);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELL_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        WAIT_SWAP
    } state_t;

    state_t            state_reg;
    logic [WORD_W-1:0] shift_reg;
    logic [BIT_W-1:0]  bit_cnt_reg;
    logic [ADDR_W-1:0] word_cnt_reg;
    logic              bank_free_reg;
    logic              wr_en_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [WORD_W-1:0] wr_data_reg;
    logic              wr_bank_reg;
    logic              frame_done_reg;
    logic              overflow_reg;

    logic              sample_en;
    logic              swap_now;
    logic [WORD_W-1:0] shift_next;

    assign sample_en  = bus.SPI_clk_en & bus.video_data_ready;
    assign shift_next = {shift_reg[WORD_W-2:0], bus.MISO};
    // A consumed pulse arriving in the very cycle we wait is as good as a latched one.
    assign swap_now   = (state_reg == WAIT_SWAP) && (bank_free_reg || bus.frame_consumed);

    always_ff @(posedge CLK_40) begin
        if (reset) begin
            state_reg      <= IDLE;
            shift_reg      <= '0;
            bit_cnt_reg    <= '0;
            word_cnt_reg   <= '0;
            bank_free_reg  <= 1'b1;
            wr_en_reg      <= 1'b0;
            wr_addr_reg    <= '0;
            wr_data_reg    <= '0;
            wr_bank_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            wr_en_reg      <= 1'b0;
            frame_done_reg <= 1'b0;

            if (swap_now) begin
                bank_free_reg <= 1'b0;
            end else if (bus.frame_consumed) begin
                bank_free_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (bus.video_data_ready) begin
                        state_reg <= CAPTURE;
                    end
                end

                CAPTURE: begin
                    // Dropping video_data_ready simply stalls here with the partial word intact.
                    if (sample_en) begin
                        shift_reg <= shift_next;
                        if (bit_cnt_reg == LAST_BIT) begin
                            bit_cnt_reg <= '0;
                            wr_en_reg   <= 1'b1;
                            wr_data_reg <= shift_next;
                            wr_addr_reg <= word_cnt_reg;
                            if (word_cnt_reg == LAST_CELL) begin
                                frame_done_reg <= 1'b1;
                                word_cnt_reg   <= '0;
                                state_reg      <= WAIT_SWAP;
                            end else begin
                                word_cnt_reg <= word_cnt_reg + ADDR_W'(1);
                            end
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
                        end
                    end
                end

                WAIT_SWAP: begin
                    // No bank to write into: the bit is lost and the error is remembered.
                    if (sample_en) begin
                        overflow_reg <= 1'b1;
                    end
                    if (swap_now) begin
                        wr_bank_reg <= ~wr_bank_reg;
                        state_reg   <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.wr_en        = wr_en_reg;
    assign bus.wr_addr      = wr_addr_reg;
    assign bus.wr_data      = wr_data_reg;
    assign bus.wr_bank      = wr_bank_reg;
    assign bus.display_bank = ~wr_bank_reg;
    assign bus.frame_done   = frame_done_reg;
    assign bus.overflow     = overflow_reg;
endmodule

// File: tb/tb_spi_frame_writer.sv
// Bench for spi_frame_writer with a 4-word frame: a hand-written vector table, directed
// multi-cycle sequences and a randomized run, all against a behavioural model.
module tb_spi_frame_writer;
    localparam int WORD_W     = 8;
    localparam int CELL_COUNT = 4;
    localparam int ADDR_W     = 2;

    logic clk;
    logic reset;

    spi_frame_writer_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

    spi_frame_writer #(
        .WORD_W    (WORD_W),
        .CELL_COUNT(CELL_COUNT),
        .ADDR_W    (ADDR_W)
    ) dut (
        .CLK_40(clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;
    int n_writes = 0;

    // Behavioural model: 0 = idle, 1 = capturing, 2 = waiting for a free bank.
    int m_mode, m_acc, m_nbits, m_word;
    bit m_bank, m_free;
    bit exp_wr_en, exp_fd, exp_ovf;
    int exp_addr, exp_data;

    typedef struct {
        bit st, mi, vd, fc;
        bit we;
        logic [7:0] data;
        logic [1:0] addr;
        bit fd, bank, ovf;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic model_step(input bit rst, input bit st, input bit mi, input bit vd, input bit fc);
        bit en;
        bit swapped;
        exp_wr_en = 0;
        exp_fd    = 0;
        swapped   = 0;
        if (rst) begin
            m_mode = 0; m_acc = 0; m_nbits = 0; m_word = 0;
            m_bank = 0; m_free = 1;
            exp_addr = 0; exp_data = 0; exp_ovf = 0;
            return;
        end
        en = st && vd;
        case (m_mode)
            0: if (vd) m_mode = 1;
            1: if (en) begin
                m_acc = ((m_acc * 2) + int'(mi)) % 256;
                m_nbits++;
                if (m_nbits == WORD_W) begin
                    m_nbits   = 0;
                    exp_wr_en = 1;
                    exp_data  = m_acc;
                    exp_addr  = m_word;
                    if (m_word == CELL_COUNT - 1) begin
                        exp_fd = 1;
                        m_word = 0;
                        m_mode = 2;
                    end else begin
                        m_word++;
                    end
                end
            end
            default: begin
                if (en) exp_ovf = 1;
                if (m_free || fc) begin
                    m_bank  = !m_bank;
                    m_free  = 0;
                    swapped = 1;
                    m_mode  = 0;
                end
            end
        endcase
        if (fc && !swapped) m_free = 1;
    endtask

    task automatic step(input bit rst, input bit st, input bit mi, input bit vd, input bit fc,
                        input bit check);
        @(negedge clk);
        reset                = rst;
        bus.SPI_clk_en       = st;
        bus.MISO             = mi;
        bus.video_data_ready = vd;
        bus.frame_consumed   = fc;
        @(posedge clk);
        model_step(rst, st, mi, vd, fc);
        #1;
        if (bus.wr_en) n_writes++;
        if (check) begin
            chk("wr_en",        int'(bus.wr_en),        int'(exp_wr_en));
            chk("frame_done",   int'(bus.frame_done),   int'(exp_fd));
            chk("wr_addr",      int'(bus.wr_addr),      exp_addr);
            chk("wr_data",      int'(bus.wr_data),      exp_data);
            chk("wr_bank",      int'(bus.wr_bank),      int'(m_bank));
            chk("display_bank", int'(bus.display_bank), int'(!m_bank));
            chk("overflow",     int'(bus.overflow),     int'(exp_ovf));
        end
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 1);
        step(1, 1, 1, 1, 0, 1);
    endtask

    task automatic send_bit(input bit mi, input bit vd);
        step(0, 1, mi, vd, 0, 1);
        step(0, 0, 1'($urandom_range(0, 1)), vd, 0, 1);
        step(0, 0, 1'($urandom_range(0, 1)), vd, 0, 1);
    endtask

    initial begin
        reset                = 1'b1;
        bus.SPI_clk_en       = 1'b0;
        bus.MISO             = 1'b0;
        bus.video_data_ready = 1'b0;
        bus.frame_consumed   = 1'b0;

        // Table: one idle-to-capture cycle, then 1,0,1,0,0,1,0,1 on back-to-back strobes.
        tbl[0] = '{0, 0, 1, 0, 0, 8'h00, 2'd0, 0, 0, 0};
        tbl[1] = '{1, 1, 1, 0, 0, 8'h00, 2'd0, 0, 0, 0};
        tbl[2] = '{1, 0, 1, 0, 0, 8'h00, 2'd0, 0, 0, 0};
        tbl[3] = '{1, 1, 1, 0, 0, 8'h00, 2'd0, 0, 0, 0};
        tbl[4] = '{1, 0, 1, 0, 0, 8'h00, 2'd0, 0, 0, 0};
        tbl[5] = '{1, 0, 1, 0, 0, 8'h00, 2'd0, 0, 0, 0};
        tbl[6] = '{1, 1, 1, 0, 0, 8'h00, 2'd0, 0, 0, 0};
        tbl[7] = '{1, 0, 1, 0, 0, 8'h00, 2'd0, 0, 0, 0};
        tbl[8] = '{1, 1, 1, 0, 1, 8'hA5, 2'd0, 0, 0, 0};
        tbl[9] = '{0, 1, 1, 0, 0, 8'hA5, 2'd0, 0, 0, 0};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(0, tbl[i].st, tbl[i].mi, tbl[i].vd, tbl[i].fc, 0);
            chk($sformatf("tbl%0d_wr_en", i),   int'(bus.wr_en),        int'(tbl[i].we));
            chk($sformatf("tbl%0d_wr_data", i), int'(bus.wr_data),      int'(tbl[i].data));
            chk($sformatf("tbl%0d_wr_addr", i), int'(bus.wr_addr),      int'(tbl[i].addr));
            chk($sformatf("tbl%0d_fd", i),      int'(bus.frame_done),   int'(tbl[i].fd));
            chk($sformatf("tbl%0d_bank", i),    int'(bus.wr_bank),      int'(tbl[i].bank));
            chk($sformatf("tbl%0d_disp", i),    int'(bus.display_bank), int'(!tbl[i].bank));
            chk($sformatf("tbl%0d_ovf", i),     int'(bus.overflow),     int'(tbl[i].ovf));
        end

        // Stall mid-word: strobes with video_data_ready low must not contribute bits.
        do_reset();
        step(0, 0, 0, 1, 0, 1);
        send_bit(1, 1); send_bit(1, 1); send_bit(0, 1); send_bit(0, 1);
        for (int i = 0; i < 20; i++) step(0, 1, 1'(i % 2), 0, 0, 1);
        send_bit(1, 1); send_bit(0, 1); send_bit(1, 1); send_bit(1, 1);
        chk("stall_word_data", int'(bus.wr_data), 8'hCB);
        chk("stall_word_addr", int'(bus.wr_addr), 0);

        // Full frame with a free bank, then a second frame with nobody consuming.
        do_reset();
        step(0, 0, 0, 1, 0, 1);
        n_writes = 0;
        for (int i = 0; i < 32; i++) send_bit(1'($urandom_range(0, 1)), 1);
        chk("frame1_writes", n_writes, 4);
        chk("frame1_wr_bank", int'(bus.wr_bank), 1);
        chk("frame1_display_bank", int'(bus.display_bank), 0);
        for (int i = 0; i < 32; i++) send_bit(1'($urandom_range(0, 1)), 1);
        step(0, 0, 0, 1, 0, 1);
        chk("frame2_hold_bank", int'(bus.wr_bank), 1);
        chk("frame2_no_overflow_yet", int'(bus.overflow), 0);
        for (int i = 0; i < 3; i++) send_bit(1, 1);
        chk("overflow_set", int'(bus.overflow), 1);
        step(0, 0, 0, 1, 1, 1);
        step(0, 0, 0, 1, 0, 1);
        chk("late_swap_bank", int'(bus.wr_bank), 0);
        chk("overflow_sticky", int'(bus.overflow), 1);

        // frame_consumed during capture is latched; swap follows frame_done immediately.
        do_reset();
        step(0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 32; i++) send_bit(1'($urandom_range(0, 1)), 1);
        for (int i = 0; i < 12; i++) send_bit(1'($urandom_range(0, 1)), 1);
        step(0, 0, 0, 1, 1, 1);
        for (int i = 0; i < 19; i++) send_bit(1'($urandom_range(0, 1)), 1);
        step(0, 1, 1, 1, 0, 1);
        chk("latched_frame_done", int'(bus.frame_done), 1);
        chk("latched_bank_before", int'(bus.wr_bank), 1);
        step(0, 0, 0, 1, 0, 1);
        chk("latched_bank_after", int'(bus.wr_bank), 0);

        // Reset in the middle of the third word discards the partial frame.
        do_reset();
        step(0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 21; i++) send_bit(1'($urandom_range(0, 1)), 1);
        do_reset();
        chk("rst_wr_addr", int'(bus.wr_addr), 0);
        chk("rst_wr_data", int'(bus.wr_data), 0);
        chk("rst_display_bank", int'(bus.display_bank), 1);
        step(0, 1, 1, 1, 0, 1);
        chk("rst_no_write_after", int'(bus.wr_en), 0);
        for (int i = 0; i < 8; i++) send_bit(1'($urandom_range(0, 1)), 1);
        chk("rst_restart_addr", int'(bus.wr_addr), 0);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 999) == 0,
                 $urandom_range(0, 2) == 0,
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 149) == 0,
                 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/spi_frame_writer.md
SPI_FRAME_WRITER -- requirements
Module: spi_frame_writer

Interface
REQ-001 Parameter WORD_W, default 8, bits per video memory word.
REQ-002 Parameter CELL_COUNT, default 9600, words per video frame; SHALL equal the VIDEO_MEM_CELL_COUNT define used by the data FSM.
REQ-003 Parameter ADDR_W, default 14, word address width; SHALL satisfy 2^ADDR_W >= CELL_COUNT.
REQ-004 CLK_40  in  1  system clock; all logic SHALL be on its rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 SPI_clk_en  in  1  one-CLK_40-cycle strobe marking each MISO sample point.
REQ-007 MISO  in  1  serial video data, MSB of each word first.
REQ-008 video_data_ready  in  1  capture enable from the data FSM (high during RECEIVE_V).
REQ-009 frame_consumed  in  1  one-cycle pulse from the display reader: display bank fully scanned and free.
REQ-010 wr_en  out  1  frame-buffer write strobe, one CLK_40 cycle per word.
REQ-011 wr_addr  out  ADDR_W  word address within the write bank.
REQ-012 wr_data  out  WORD_W  assembled word.
REQ-013 wr_bank  out  1  bank currently being written.
REQ-014 display_bank  out  1  bank the display SHALL read; always ~wr_bank.
REQ-015 frame_done  out  1  one-cycle pulse when the last word of a frame is written.
REQ-016 overflow  out  1  sticky error flag: data arrived with no free bank.

Function
REQ-017 States: IDLE, CAPTURE, WAIT_SWAP.
REQ-018 IDLE -> CAPTURE when video_data_ready=1; otherwise stay.
REQ-019 In CAPTURE, on each cycle with SPI_clk_en=1 and video_data_ready=1: shift_reg <= {shift_reg[WORD_W-2:0], MISO}; bit_cnt increments.
REQ-020 When video_data_ready drops mid-word, shift_reg and bit_cnt SHALL hold; capture resumes on re-assertion without loss.
REQ-021 On the sample that completes a word (bit_cnt = WORD_W-1), the next CLK_40 cycle SHALL drive wr_en=1, wr_data=completed word, wr_addr=word_cnt; bit_cnt returns to 0.
REQ-022 word_cnt SHALL increment after each write; it is not incremented on any other cycle.
REQ-023 The write of word_cnt = CELL_COUNT-1 SHALL assert frame_done in the same cycle as that wr_en, clear word_cnt to 0, and enter WAIT_SWAP.
REQ-024 bank_free flag: set by frame_consumed; cleared on swap; frame_consumed arriving in any state SHALL be latched, never lost.
REQ-025 In WAIT_SWAP with bank_free=1 (including a same-cycle frame_consumed pulse): wr_bank <= ~wr_bank, bank_free <= 0, state <= IDLE.
REQ-026 In WAIT_SWAP, any cycle with SPI_clk_en=1 and video_data_ready=1 SHALL set overflow; the bit SHALL be dropped and no write issued.
REQ-027 overflow SHALL clear only on reset.
REQ-028 Outside REQ-021/023 timing, wr_en and frame_done SHALL be 0; wr_addr/wr_data SHALL hold their last values.
REQ-029 MISO SHALL be ignored whenever SPI_clk_en=0 or video_data_ready=0.

Reset
REQ-030 On reset: state=IDLE, wr_en=0, wr_addr=0, wr_data=0, wr_bank=0, display_bank=1, frame_done=0, overflow=0, bit_cnt=0, word_cnt=0, shift_reg=0, bank_free=1.
REQ-031 Reset asserted mid-word or mid-frame SHALL discard the partial word/frame; no write issues in the cycle after reset deasserts.

Verification
REQ-032 Send 8 bits 1,0,1,0,0,1,0,1 with video_data_ready=1 -> one wr_en pulse, wr_data=8'hA5, wr_addr=0, one cycle after the 8th strobe.
REQ-033 Send 4 bits, drop video_data_ready for 20 strobes (MISO toggling), then send 4 more -> single word built only from the 8 enabled bits.
REQ-034 CELL_COUNT=4, stream 32 bits, bank_free=1 -> 4 writes at addresses 0..3, frame_done coincident with the 4th wr_en, then wr_bank 0->1, display_bank 1->0.
REQ-035 Second frame with no frame_consumed -> state holds WAIT_SWAP, wr_bank stays 1; further enabled strobes set overflow=1; a later frame_consumed pulse swaps banks, overflow stays 1.
REQ-036 frame_consumed pulsed during CAPTURE -> latched; at frame end the swap occurs one cycle after frame_done with no wait.
REQ-037 Assert reset after 5 bits of word 3 -> all outputs at REQ-030 values; next 8 bits produce a write at wr_addr=0.
